// File: rtl/weigh_pkg.sv
// Shared types and limits for the weigh scale sequencer.
package weigh_pkg;

   localparam int ADC_W = 24;

   localparam logic signed [ADC_W:0] SAT_MAX = 25'sd8388607;
   localparam logic signed [ADC_W:0] SAT_MIN = -25'sd8388608;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      CALC
   } state_t;

endpackage

// File: rtl/weigh_stable_det.sv
// Tracks consecutive small changes between averages and flags a steady reading.
module weigh_stable_det
   import weigh_pkg::*;
#(
   parameter int STABLE_TOL = 16,
   parameter int STABLE_CNT = 3
) (
   input  logic                    clk_50,
   input  logic                    rst_n,
   input  logic                    upd,
   input  logic                    clr,
   input  logic signed [ADC_W-1:0] avg,
   output logic                    stable
);

   localparam int CW = $clog2(STABLE_CNT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
   localparam logic signed [ADC_W:0] TOL = (ADC_W + 1)'(STABLE_TOL);

   logic signed [ADC_W-1:0] prev_avg;
   logic [CW-1:0]           steady_cnt;
   logic signed [ADC_W:0]   diff;
   logic signed [ADC_W:0]   dabs;
   logic                    steady;
   logic [CW-1:0]           cnt_nxt;

   // The 25-bit difference cannot overflow, so negation is always safe.
   always_comb begin
      diff    = {avg[ADC_W-1], avg} - {prev_avg[ADC_W-1], prev_avg};
      dabs    = (diff < 0) ? -diff : diff;
      steady  = (dabs <= TOL);
      cnt_nxt = '0;
      if (steady) begin
         cnt_nxt = (steady_cnt == CNT_MAX) ? CNT_MAX : steady_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         prev_avg   <= '0;
         steady_cnt <= '0;
         stable     <= 1'b0;
      end else if (clr) begin
         steady_cnt <= '0;
         stable     <= 1'b0;
      end else if (upd) begin
         prev_avg   <= avg;
         steady_cnt <= cnt_nxt;
         stable     <= (cnt_nxt == CNT_MAX);
      end
   end

endmodule

// File: rtl/weigh_ctrl.sv
// Periodic HX711 conversion sequencer: averages samples, applies tare, saturates,
// reports stability and a sticky ADC timeout.
module weigh_ctrl
   import weigh_pkg::*;
#(
   parameter int AVG_LOG2    = 2,
   parameter int PERIOD_CYC  = 50000,
   parameter int TIMEOUT_CYC = 6000000,
   parameter int STABLE_TOL  = 16,
   parameter int STABLE_CNT  = 3
) (
   input  logic                    clk_50,
   input  logic                    rst_n,
   output logic                    conv_req,
   input  logic                    conv_done,
   input  logic [ADC_W-1:0]        conv_data,
   input  logic                    tare_req,
   output logic                    tare_busy,
   output logic signed [ADC_W-1:0] weight,
   output logic                    weight_valid,
   output logic                    stable,
   output logic                    err_timeout
);

   localparam int ACC_W = ADC_W + AVG_LOG2;
   localparam int CW    = AVG_LOG2 + 1;
   localparam int PW    = $clog2(PERIOD_CYC + 1);
   localparam int TW    = $clog2(TIMEOUT_CYC + 1);

   localparam logic [CW-1:0] NSAMP    = CW'(1 << AVG_LOG2);
   localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYC - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

   state_t                  state;
   logic [PW-1:0]           per_cnt;
   logic [TW-1:0]           to_cnt;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_nxt;
   logic [CW-1:0]           cnt;
   logic [CW-1:0]           cnt_nxt;
   logic signed [ADC_W-1:0] tare_reg;
   logic                    tare_pend;
   logic signed [ADC_W-1:0] avg;
   logic signed [ADC_W:0]   net;
   logic                    to_fire;

   function automatic logic signed [ADC_W-1:0] sat24(input logic signed [ADC_W:0] x);
      if (x > SAT_MAX) return SAT_MAX[ADC_W-1:0];
      if (x < SAT_MIN) return SAT_MIN[ADC_W-1:0];
      return x[ADC_W-1:0];
   endfunction

   // Dropping the low bits of the signed sum is the floor division by 2^AVG_LOG2.
   always_comb begin
      acc_nxt = acc + {{AVG_LOG2{conv_data[ADC_W-1]}}, conv_data};
      cnt_nxt = cnt + CW'(1);
      avg     = acc[ACC_W-1:AVG_LOG2];
      net     = {avg[ADC_W-1], avg} - {tare_reg[ADC_W-1], tare_reg};
      to_fire = (state == WAIT) && !conv_done && (to_cnt == TO_LAST);
   end

   assign tare_busy = tare_pend;

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         per_cnt      <= '0;
         to_cnt       <= '0;
         acc          <= '0;
         cnt          <= '0;
         tare_reg     <= '0;
         tare_pend    <= 1'b0;
         conv_req     <= 1'b0;
         weight       <= '0;
         weight_valid <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         conv_req     <= 1'b0;
         weight_valid <= 1'b0;
         if (tare_req) tare_pend <= 1'b1;
         case (state)
            IDLE: begin
               if (per_cnt == PER_LAST) begin
                  per_cnt  <= '0;
                  conv_req <= 1'b1;
                  state    <= REQ;
               end else begin
                  per_cnt <= per_cnt + PW'(1);
               end
            end
            REQ: begin
               to_cnt <= '0;
               state  <= WAIT;
            end
            WAIT: begin
               // A sample landing on the expiry cycle still counts.
               if (conv_done) begin
                  acc         <= acc_nxt;
                  cnt         <= cnt_nxt;
                  err_timeout <= 1'b0;
                  state       <= (cnt_nxt == NSAMP) ? CALC : IDLE;
               end else if (to_fire) begin
                  err_timeout <= 1'b1;
                  acc         <= '0;
                  cnt         <= '0;
                  state       <= IDLE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            CALC: begin
               if (tare_pend || tare_req) begin
                  tare_reg  <= avg;
                  weight    <= '0;
                  tare_pend <= 1'b0;
               end else begin
                  weight <= sat24(net);
               end
               weight_valid <= 1'b1;
               acc          <= '0;
               cnt          <= '0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   weigh_stable_det #(
      .STABLE_TOL(STABLE_TOL),
      .STABLE_CNT(STABLE_CNT)
   ) u_stable (
      .clk_50(clk_50),
      .rst_n (rst_n),
      .upd   (state == CALC),
      .clr   (to_fire),
      .avg   (avg),
      .stable(stable)
   );

endmodule

// File: tb/tb_weigh_ctrl.sv
// Directed bench for weigh_ctrl: table of averaging vectors plus timeout and reset sequences.
module tb_weigh_ctrl;

   localparam int P = 10;
   localparam int T = 200;

   logic        clk_50 = 1'b0;
   logic        rst_n = 1'b1;
   logic        conv_done = 1'b0;
   logic [23:0] conv_data = 24'h0;
   logic        tare_req = 1'b0;
   logic        conv_req;
   logic        tare_busy;
   logic [23:0] weight;
   logic        weight_valid;
   logic        stable;
   logic        err_timeout;

   weigh_ctrl #(
      .AVG_LOG2(2), .PERIOD_CYC(P), .TIMEOUT_CYC(T), .STABLE_TOL(16), .STABLE_CNT(3)
   ) dut (
      .clk_50(clk_50), .rst_n(rst_n), .conv_req(conv_req), .conv_done(conv_done),
      .conv_data(conv_data), .tare_req(tare_req), .tare_busy(tare_busy),
      .weight(weight), .weight_valid(weight_valid), .stable(stable),
      .err_timeout(err_timeout)
   );

   always #5 clk_50 = ~clk_50;

   int cyc = 0;
   int req_total = 0;
   always @(posedge clk_50) cyc <= cyc + 1;
   always @(negedge clk_50) if (conv_req) req_total <= req_total + 1;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic            rst;
      logic [1:0]      tmode;   // 0 none, 1 tare before samples, 2 tare in the CALC cycle
      logic [3:0][23:0] s;
      logic [23:0]     exp_w;
      logic            exp_st;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic [1:0] tm, input logic [23:0] a,
                               input logic [23:0] b, input logic [23:0] c, input logic [23:0] d,
                               input logic [23:0] w, input logic st);
      vec_t v;
      v.rst = r; v.tmode = tm;
      v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
      v.exp_w = w; v.exp_st = st;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk_50);
      rst_n = 1'b0; conv_done = 1'b0; tare_req = 1'b0;
      repeat (2) @(negedge clk_50);
      rst_n = 1'b1;
   endtask

   task automatic wait_req(output int t, output bit ok);
      ok = 1'b0; t = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk_50);
         if (conv_req) begin ok = 1'b1; t = cyc; break; end
      end
   endtask

   task automatic respond(input logic [23:0] d, output int t_done);
      repeat (2) @(negedge clk_50);
      conv_done = 1'b1; conv_data = d; t_done = cyc;
      @(negedge clk_50);
      conv_done = 1'b0; conv_data = 24'h0;
   endtask

   task automatic do_conv(input string tag, input logic [23:0] d, output int t_req, output int t_done);
      bit ok;
      wait_req(t_req, ok);
      chk({tag, "_req_seen"}, 32'(ok), 1);
      respond(d, t_done);
   endtask

   task automatic run_avg(input vec_t v, input string tag, output int t_first);
      int t_req, t_done, prev_done, base, t_wv;
      bit ok;
      prev_done = 0; t_wv = 0; t_first = 0;
      if (v.rst) do_reset();
      base = req_total;
      if (v.tmode == 2'd1) begin
         @(negedge clk_50); tare_req = 1'b1;
         @(negedge clk_50); tare_req = 1'b0;
         chk({tag, "_tare_busy_set"}, 32'(tare_busy), 1);
      end
      for (int i = 0; i < 4; i++) begin
         do_conv(tag, v.s[i], t_req, t_done);
         if (i == 0) t_first = t_req;
         else chk({tag, "_idle_gap"}, t_req - prev_done, P + 1);
         prev_done = t_done;
      end
      if (v.tmode == 2'd2) tare_req = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk_50);
         tare_req = 1'b0;
         if (weight_valid) begin ok = 1'b1; t_wv = cyc; break; end
      end
      chk({tag, "_wv_seen"}, 32'(ok), 1);
      chk({tag, "_latency"}, t_wv - t_done, 2);
      chk({tag, "_weight"}, 32'(weight), 32'(v.exp_w));
      chk({tag, "_stable"}, 32'(stable), 32'(v.exp_st));
      chk({tag, "_tare_busy"}, 32'(tare_busy), 0);
      chk({tag, "_nreq"}, req_total - base, 4);
      @(negedge clk_50);
      chk({tag, "_wv_pulse"}, 32'(weight_valid), 0);
   endtask

   initial begin
      int tf, t_req, t_done, t_err;
      bit ok;

      vecs[0]  = mk(1, 0, 24'd1000, 24'd1000, 24'd1000, 24'd1004, 24'd1001, 0);
      vecs[1]  = mk(0, 1, 24'd1000, 24'd1000, 24'd1000, 24'd1000, 24'd0, 0);
      vecs[2]  = mk(0, 0, 24'd1500, 24'd1500, 24'd1500, 24'd1500, 24'd500, 0);
      vecs[3]  = mk(1, 0, 24'hFFFF9C, 24'hFFFF9C, 24'hFFFF9C, 24'hFFFF9C, 24'hFFFF9C, 0);
      vecs[4]  = mk(0, 2, 24'h800000, 24'h800000, 24'h800000, 24'h800000, 24'd0, 0);
      vecs[5]  = mk(0, 0, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 0);
      vecs[6]  = mk(1, 0, 24'd500, 24'd500, 24'd500, 24'd500, 24'd500, 0);
      vecs[7]  = mk(0, 0, 24'd505, 24'd505, 24'd505, 24'd505, 24'd505, 0);
      vecs[8]  = mk(0, 0, 24'd510, 24'd510, 24'd510, 24'd510, 24'd510, 0);
      vecs[9]  = mk(0, 0, 24'd512, 24'd512, 24'd512, 24'd512, 24'd512, 1);
      vecs[10] = mk(0, 0, 24'd700, 24'd700, 24'd700, 24'd700, 24'd700, 0);
      vecs[11] = mk(0, 0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFE, 0);
      vecs[12] = mk(1, 1, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'd0, 0);
      vecs[13] = mk(0, 0, 24'h800000, 24'h800000, 24'h800000, 24'h800000, 24'h800000, 0);

      #2 rst_n = 1'b0;
      #1;
      chk("rst_conv_req", 32'(conv_req), 0);
      chk("rst_tare_busy", 32'(tare_busy), 0);
      chk("rst_weight", 32'(weight), 0);
      chk("rst_weight_valid", 32'(weight_valid), 0);
      chk("rst_stable", 32'(stable), 0);
      chk("rst_err_timeout", 32'(err_timeout), 0);
      repeat (2) @(negedge clk_50);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         run_avg(vecs[i], $sformatf("vec%0d", i), tf);
      end

      // Timeout: build stability, leave a partial sum, then starve the reader.
      run_avg(mk(1, 0, 24'd500, 24'd500, 24'd500, 24'd500, 24'd500, 0), "to_a", tf);
      run_avg(mk(0, 0, 24'd500, 24'd500, 24'd500, 24'd500, 24'd500, 0), "to_b", tf);
      run_avg(mk(0, 0, 24'd500, 24'd500, 24'd500, 24'd500, 24'd500, 0), "to_c", tf);
      run_avg(mk(0, 0, 24'd500, 24'd500, 24'd500, 24'd500, 24'd500, 1), "to_d", tf);
      do_conv("to_p1", 24'd5000, t_req, t_done);
      do_conv("to_p2", 24'd5000, t_req, t_done);
      wait_req(t_req, ok);
      chk("to_req_seen", 32'(ok), 1);
      ok = 1'b0; t_err = 0;
      for (int n = 0; n < T + 20; n++) begin
         @(negedge clk_50);
         if (err_timeout) begin ok = 1'b1; t_err = cyc; break; end
      end
      chk("to_err_seen", 32'(ok), 1);
      chk("to_err_time", t_err - t_req, T + 1);
      chk("to_stable_clr", 32'(stable), 0);
      repeat (5) @(negedge clk_50);
      chk("to_err_sticky", 32'(err_timeout), 1);
      run_avg(mk(0, 0, 24'd100, 24'd100, 24'd100, 24'd100, 24'd100, 0), "to_fresh", tf);
      chk("to_retry_gap", tf - t_err, P);
      chk("to_err_cleared", 32'(err_timeout), 0);

      // Asynchronous reset mid-WAIT with two samples accumulated and a tare pending.
      do_reset();
      run_avg(mk(0, 0, 24'd9000, 24'd9000, 24'd9000, 24'd9000, 24'd9000, 0), "ar_pre", tf);
      @(negedge clk_50); tare_req = 1'b1;
      @(negedge clk_50); tare_req = 1'b0;
      do_conv("ar_s1", 24'd9000, t_req, t_done);
      do_conv("ar_s2", 24'd9000, t_req, t_done);
      wait_req(t_req, ok);
      chk("ar_req_seen", 32'(ok), 1);
      @(negedge clk_50);
      rst_n = 1'b0;
      #1;
      chk("ar_weight", 32'(weight), 0);
      chk("ar_tare_busy", 32'(tare_busy), 0);
      chk("ar_conv_req", 32'(conv_req), 0);
      chk("ar_err", 32'(err_timeout), 0);
      @(negedge clk_50); conv_done = 1'b1; conv_data = 24'h7FFFFF;
      @(negedge clk_50); conv_done = 1'b0;
      @(negedge clk_50); rst_n = 1'b1;
      @(negedge clk_50); conv_done = 1'b1; conv_data = 24'h7FFFFF;
      @(negedge clk_50); conv_done = 1'b0; conv_data = 24'h0;
      run_avg(mk(0, 0, 24'd20, 24'd20, 24'd20, 24'd20, 24'd20, 0), "ar_post", tf);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
